// File: rtl/hack_mem_pkg.sv
// Shared address map, keyboard codes and read-mux region type for the Hack
// data-bus memory responder.
package hack_mem_pkg;

  localparam logic [14:0] RAM_BASE     = 15'h0000;
  localparam logic [14:0] SCREEN_BASE  = 15'h4000;
  localparam logic [14:0] KBD_ADDR     = 15'h6000;
  localparam int          SCREEN_WORDS = 8192;

  localparam logic [15:0] KEY_NONE  = 16'd0;
  localparam logic [15:0] KEY_LEFT  = 16'd130;
  localparam logic [15:0] KEY_UP    = 16'd131;
  localparam logic [15:0] KEY_RIGHT = 16'd132;
  localparam logic [15:0] KEY_DOWN  = 16'd133;

  typedef enum logic [1:0] {
    REG_NONE   = 2'd0,
    REG_RAM    = 2'd1,
    REG_SCREEN = 2'd2,
    REG_KBD    = 2'd3
  } region_e;

  // RAM region above the implemented depth decodes as unmapped.
  function automatic region_e decode_region(input logic [14:0] addr,
                                            input logic [14:0] ram_limit);
    region_e r;
    if (addr < SCREEN_BASE) begin
      if (addr < ram_limit) r = REG_RAM;
      else                  r = REG_NONE;
    end else if (addr < KBD_ADDR) begin
      r = REG_SCREEN;
    end else if (addr == KBD_ADDR) begin
      r = REG_KBD;
    end else begin
      r = REG_NONE;
    end
    return r;
  endfunction

endpackage

// File: rtl/hack_key_debounce.sv
// One board key: 2-flop synchronizer, debounce counter and accepted level.
// pressed_o is high while the accepted (active-low) level is low.
module hack_key_debounce
  #(parameter int DEBOUNCE_CYCLES = 1000000)
  (
    input  logic clk,
    input  logic reset_n,
    input  logic key_n_i,
    output logic pressed_o
  );

  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_CYCLES - 1);

  logic          sync1_q, sync2_q;
  logic          level_q, level_d;
  logic [CW-1:0] cnt_q, cnt_d;

  always_comb begin
    level_d = level_q;
    cnt_d   = cnt_q;
    if (sync2_q != level_q) begin
      if (cnt_q == CNT_MAX) begin
        level_d = ~level_q;
        cnt_d   = '0;
      end else begin
        cnt_d = cnt_q + CW'(1);
      end
    end else begin
      cnt_d = '0;
    end
  end

  // Synchronizer idles high so a reset never registers as a press.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync1_q <= 1'b1;
      sync2_q <= 1'b1;
      level_q <= 1'b1;
      cnt_q   <= '0;
    end else begin
      sync1_q <= key_n_i;
      sync2_q <= sync1_q;
      level_q <= level_d;
      cnt_q   <= cnt_d;
    end
  end

  assign pressed_o = ~level_q;

endmodule

// File: rtl/hack_data_mem.sv
// Hack CPU data-bus responder: general RAM, dual-port screen RAM with a video
// read port, and the debounced keyboard register at 0x6000.
module hack_data_mem
  import hack_mem_pkg::*;
  #(
    parameter int RAM_WORDS       = 4096,
    parameter int DEBOUNCE_CYCLES = 1000000
  )
  (
    input  logic        clk,
    input  logic        reset_n,
    input  logic [14:0] data_address_bus,
    input  logic [15:0] data_out_bus,
    input  logic        write_enable,
    output logic [15:0] data_in_bus,
    input  logic [12:0] vid_addr,
    output logic [15:0] vid_data,
    input  logic        key0,
    input  logic        key1,
    input  logic        key2,
    input  logic        key3,
    output logic [15:0] kbd_code
  );

  localparam int          RAM_AW    = (RAM_WORDS > 1) ? $clog2(RAM_WORDS) : 1;
  localparam logic [14:0] RAM_LIMIT = 15'(RAM_WORDS);

  logic [15:0] ram_mem    [RAM_WORDS];
  logic [15:0] screen_mem [SCREEN_WORDS];

  region_e     region_d, region_q;
  logic [15:0] ram_rd_q, scr_rd_q, vid_rd_q;
  logic        vid_valid_q;
  logic [15:0] kbd_code_d, kbd_code_q;
  logic [3:0]  pressed_s;

  assign region_d = decode_region(data_address_bus, RAM_LIMIT);

  // Memory arrays carry no reset; reads use the pre-write contents (read-first).
  always_ff @(posedge clk) begin
    ram_rd_q <= ram_mem[data_address_bus[RAM_AW-1:0]];
    scr_rd_q <= screen_mem[data_address_bus[12:0]];
    vid_rd_q <= screen_mem[vid_addr];
    if (write_enable && (region_d == REG_RAM)) begin
      ram_mem[data_address_bus[RAM_AW-1:0]] <= data_out_bus;
    end
    if (write_enable && (region_d == REG_SCREEN)) begin
      screen_mem[data_address_bus[12:0]] <= data_out_bus;
    end
  end

  hack_key_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_key0 (
    .clk(clk), .reset_n(reset_n), .key_n_i(key0), .pressed_o(pressed_s[0]));
  hack_key_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_key1 (
    .clk(clk), .reset_n(reset_n), .key_n_i(key1), .pressed_o(pressed_s[1]));
  hack_key_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_key2 (
    .clk(clk), .reset_n(reset_n), .key_n_i(key2), .pressed_o(pressed_s[2]));
  hack_key_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_key3 (
    .clk(clk), .reset_n(reset_n), .key_n_i(key3), .pressed_o(pressed_s[3]));

  always_comb begin
    kbd_code_d = KEY_NONE;
    if      (pressed_s[0]) kbd_code_d = KEY_LEFT;
    else if (pressed_s[1]) kbd_code_d = KEY_UP;
    else if (pressed_s[2]) kbd_code_d = KEY_RIGHT;
    else if (pressed_s[3]) kbd_code_d = KEY_DOWN;
    else                   kbd_code_d = KEY_NONE;
  end

  // Region select and video-valid force both read ports to zero during reset.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      region_q    <= REG_NONE;
      vid_valid_q <= 1'b0;
      kbd_code_q  <= 16'h0000;
    end else begin
      region_q    <= region_d;
      vid_valid_q <= 1'b1;
      kbd_code_q  <= kbd_code_d;
    end
  end

  always_comb begin
    data_in_bus = 16'h0000;
    case (region_q)
      REG_RAM:    data_in_bus = ram_rd_q;
      REG_SCREEN: data_in_bus = scr_rd_q;
      REG_KBD:    data_in_bus = kbd_code_q;
      REG_NONE:   data_in_bus = 16'h0000;
      default:    data_in_bus = 16'h0000;
    endcase
  end

  assign vid_data = vid_valid_q ? vid_rd_q : 16'h0000;
  assign kbd_code = kbd_code_q;

endmodule

// File: tb/tb_hack_data_mem.sv
// Directed plus randomized bench for hack_data_mem against an address-map
// reference model held in associative arrays.
module tb_hack_data_mem;

  localparam int RAM_WORDS = 4096;
  localparam int DEB       = 8;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic [14:0] data_address_bus = 15'h0000;
  logic [15:0] data_out_bus = 16'h0000;
  logic        write_enable = 1'b0;
  logic [15:0] data_in_bus;
  logic [12:0] vid_addr = 13'h0000;
  logic [15:0] vid_data;
  logic        key0 = 1'b1, key1 = 1'b1, key2 = 1'b1, key3 = 1'b1;
  logic [15:0] kbd_code;

  int checks = 0;
  int errors = 0;

  logic [15:0] ram_m [int];
  logic [15:0] scr_m [int];
  logic [15:0] kbd_exp = 16'h0000;

  hack_data_mem #(.RAM_WORDS(RAM_WORDS), .DEBOUNCE_CYCLES(DEB)) dut (
    .clk(clk), .reset_n(reset_n),
    .data_address_bus(data_address_bus), .data_out_bus(data_out_bus),
    .write_enable(write_enable), .data_in_bus(data_in_bus),
    .vid_addr(vid_addr), .vid_data(vid_data),
    .key0(key0), .key1(key1), .key2(key2), .key3(key3),
    .kbd_code(kbd_code));

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Expected CPU read value straight from the address map.
  task automatic model_read(input logic [14:0] a, output logic known, output logic [15:0] v);
    int ai;
    ai = int'(a);
    known = 1'b1;
    v = 16'h0000;
    if (ai < RAM_WORDS) begin
      known = ram_m.exists(ai);
      if (known) v = ram_m[ai];
    end else if (ai < 16'h4000) begin
      v = 16'h0000;
    end else if (ai < 16'h6000) begin
      known = scr_m.exists(ai - 16'h4000);
      if (known) v = scr_m[ai - 16'h4000];
    end else if (ai == 16'h6000) begin
      v = kbd_exp;
    end else begin
      v = 16'h0000;
    end
  endtask

  task automatic model_write(input logic [14:0] a, input logic [15:0] d);
    int ai;
    ai = int'(a);
    if (ai < RAM_WORDS)                   ram_m[ai] = d;
    else if (ai >= 16'h4000 && ai < 16'h6000) scr_m[ai - 16'h4000] = d;
  endtask

  task automatic do_cycle(input logic [14:0] a, input logic w, input logic [15:0] d,
                          input logic [12:0] va, input string tag);
    logic kd, kv;
    logic [15:0] ed, ev;
    model_read(a, kd, ed);
    kv = scr_m.exists(int'(va));
    ev = kv ? scr_m[int'(va)] : 16'h0000;
    data_address_bus = a;
    write_enable     = w;
    data_out_bus     = d;
    vid_addr         = va;
    step();
    if (kd) check({tag, "_rd"}, data_in_bus, ed);
    if (kv) check({tag, "_vid"}, vid_data, ev);
    if (w) model_write(a, d);
    write_enable = 1'b0;
  endtask

  task automatic wait_kbd(input logic [15:0] e, input int maxc, input string tag);
    int n;
    n = 0;
    while (kbd_code !== e && n < maxc) begin
      step();
      n++;
    end
    check(tag, kbd_code, e);
  endtask

  initial begin
    logic [14:0] ra;
    logic [12:0] rv;
    logic [15:0] rd;
    logic        rw;

    // Reset state
    #12;
    check("rst_data_in", data_in_bus, 16'h0000);
    check("rst_vid", vid_data, 16'h0000);
    check("rst_kbd", kbd_code, 16'h0000);
    @(negedge clk);
    reset_n = 1'b1;
    step();

    // RAM path
    do_cycle(15'h0005, 1'b1, 16'h1234, 13'h0000, "ram_wr");
    do_cycle(15'h0005, 1'b0, 16'h0000, 13'h0000, "ram_rd");
    check("ram_rd_value", data_in_bus, 16'h1234);
    do_cycle(15'h2000, 1'b1, 16'h5555, 13'h0000, "ram_hi_wr");
    do_cycle(15'h2000, 1'b0, 16'h0000, 13'h0000, "ram_hi_rd");
    check("ram_beyond_depth", data_in_bus, 16'h0000);

    // Screen / video collision: seed a known old word first
    do_cycle(15'h4010, 1'b1, 16'h1111, 13'h0000, "scr_seed");
    do_cycle(15'h4010, 1'b1, 16'hBEEF, 13'h0010, "scr_collide");
    check("vid_old_word", vid_data, 16'h1111);
    do_cycle(15'h4010, 1'b0, 16'h0000, 13'h0010, "scr_reread");
    check("vid_new_word", vid_data, 16'hBEEF);
    check("cpu_scr_read", data_in_bus, 16'hBEEF);

    // Keyboard debounce: short glitch then a long press
    key1 = 1'b0;
    repeat (5) step();
    key1 = 1'b1;
    repeat (15) begin
      step();
      check("kbd_glitch", kbd_code, 16'h0000);
    end
    key1 = 1'b0;
    repeat (12) step();
    check("kbd_up", kbd_code, 16'd131);
    kbd_exp = 16'd131;
    do_cycle(15'h6000, 1'b0, 16'h0000, 13'h0010, "kbd_read");
    check("kbd_read_0x83", data_in_bus, 16'h0083);

    // Ignored writes
    do_cycle(15'h6000, 1'b1, 16'hFFFF, 13'h0010, "kbd_wr");
    do_cycle(15'h6000, 1'b0, 16'h0000, 13'h0010, "kbd_after_wr");
    do_cycle(15'h7000, 1'b1, 16'hFFFF, 13'h0010, "unmap_wr");
    do_cycle(15'h7000, 1'b0, 16'h0000, 13'h0010, "unmap_rd");
    check("unmap_zero", data_in_bus, 16'h0000);
    do_cycle(15'h0005, 1'b0, 16'h0000, 13'h0010, "ram_intact");
    do_cycle(15'h4010, 1'b0, 16'h0000, 13'h0010, "scr_intact");
    key1 = 1'b1;
    wait_kbd(16'h0000, 40, "kbd_release");
    kbd_exp = 16'h0000;

    // Key priority and release
    key3 = 1'b0;
    key0 = 1'b0;
    wait_kbd(16'd130, 40, "prio_left");
    key0 = 1'b1;
    wait_kbd(16'd133, 40, "prio_down");
    key3 = 1'b1;
    wait_kbd(16'h0000, 40, "prio_none");

    // Randomized traffic over RAM, beyond-depth, screen, KBD and unmapped
    for (int i = 0; i < 400; i++) begin
      case ($urandom_range(5, 0))
        0, 1:    ra = 15'($urandom_range(31, 0));
        2:       ra = 15'($urandom_range(16'h3FFF, RAM_WORDS));
        3:       ra = 15'(16'h4000 + $urandom_range(31, 0));
        4:       ra = 15'h6000;
        default: ra = 15'($urandom_range(16'h7FFF, 16'h6001));
      endcase
      rv = 13'($urandom_range(31, 0));
      rd = 16'($urandom);
      rw = 1'($urandom_range(1, 0));
      do_cycle(ra, rw, rd, rv, "rand");
    end

    // Asynchronous reset mid-cycle while key2 is accepted
    do_cycle(15'h0007, 1'b1, 16'hA5A5, 13'h0010, "pre_rst_wr");
    key2 = 1'b0;
    wait_kbd(16'd132, 40, "kbd_right");
    data_address_bus = 15'h6000;
    vid_addr = 13'h0010;
    step();
    #3;
    reset_n = 1'b0;
    #1;
    check("async_rst_data_in", data_in_bus, 16'h0000);
    check("async_rst_vid", vid_data, 16'h0000);
    check("async_rst_kbd", kbd_code, 16'h0000);
    key2 = 1'b1;
    kbd_exp = 16'h0000;
    repeat (3) @(posedge clk);
    @(negedge clk);
    reset_n = 1'b1;
    step();
    check("post_rst_kbd", kbd_code, 16'h0000);
    do_cycle(15'h0007, 1'b0, 16'h0000, 13'h0010, "post_rst_ram");
    check("post_rst_ram_value", data_in_bus, 16'hA5A5);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
